mmul2_sequencer: RTL and testbench

MMUL2_SEQUENCER -- requirements
Module: mmul2_sequencer

---
 rtl/mmul2_pkg.sv | 28 ++
 rtl/mmul2_idx_counter.sv | 29 ++
 rtl/mmul2_sequencer.sv | 125 ++++++++++++
 tb/tb_mmul2_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmul2_pkg.sv
// Shared definitions for the 2-operand matrix multiply index sequencer.
// State encodings and matrix dimension legality helpers.
package mmul2_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic bit dims_ok(
    input int unsigned ra,
    input int unsigned ca,
    input int unsigned rb,
    input int unsigned cb
  );
    return (ra != 0) && (rb != 0) && (cb != 0) && (ca == rb);
  endfunction

  function automatic logic [31:0] dim_max(input int unsigned d);
    return (d == 0) ? 32'd0 : 32'(d - 1);
  endfunction

endpackage

// File: rtl/mmul2_idx_counter.sv
// Wrapping index counter with carry out for chaining.
// Holds its value when hold is set so the final index stays visible.
module mmul2_idx_counter
  import mmul2_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  input  logic        hold,
  input  logic [31:0] max,
  output logic [31:0] count,
  output logic        carry
);

  assign carry = inc && (count == max);

  // count up, wrap to zero after max
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (clr) begin
      count <= 32'd0;
    end else if (inc && !hold) begin
      count <= (count == max) ? 32'd0 : count + 32'd1;
    end
  end

endmodule

// File: rtl/mmul2_sequencer.sv
// Index sequencer for C = A x B: walks i/j/k over every inner-product
// beat with a valid/ready handshake, accumulator strobes and abort.
module mmul2_sequencer
  import mmul2_pkg::*;
#(
  parameter int unsigned RA = 1,
  parameter int unsigned CA = 1,
  parameter int unsigned RB = 1,
  parameter int unsigned CB = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        step_ready,
  output logic        idx_valid,
  output logic [31:0] i,
  output logic [31:0] j,
  output logic [31:0] k,
  output logic        acc_clr,
  output logic        acc_wr,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);

  localparam bit          CFG_OK = dims_ok(RA, CA, RB, CB);
  localparam logic [31:0] I_MAX  = dim_max(RA);
  localparam logic [31:0] J_MAX  = dim_max(CB);
  localparam logic [31:0] K_MAX  = dim_max(RB);

  state_t state;
  logic   launch;
  logic   accept;
  logic   step;
  logic   last;
  logic   k_carry;
  logic   j_carry;
  logic   i_carry;

  assign cfg_err = !CFG_OK;
  assign launch  = (state == IDLE) && start && CFG_OK;
  assign accept  = idx_valid && step_ready;
  assign step    = accept && !abort;
  assign last    = (k == K_MAX) && (j == J_MAX) && (i == I_MAX);
  assign acc_clr = idx_valid && (k == 32'd0);
  assign acc_wr  = idx_valid && (k == K_MAX);

  mmul2_idx_counter u_k (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (launch),
    .inc   (step),
    .hold  (last),
    .max   (K_MAX),
    .count (k),
    .carry (k_carry)
  );

  mmul2_idx_counter u_j (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (launch),
    .inc   (k_carry),
    .hold  (last),
    .max   (J_MAX),
    .count (j),
    .carry (j_carry)
  );

  mmul2_idx_counter u_i (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (launch),
    .inc   (j_carry),
    .hold  (last),
    .max   (I_MAX),
    .count (i),
    .carry (i_carry)
  );

  // control FSM; i_carry marks the accepted final beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (launch) begin
            state     <= RUN;
            idx_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            idx_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (i_carry) begin
            state     <= DONE;
            idx_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          idx_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmul2_sequencer.sv
// Directed bench for mmul2_sequencer: three configurations share
// clock, reset, abort and step_ready; each has its own start.
module tb_mmul2_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic step_ready = 1'b0;

  logic        start2 = 1'b0;
  logic        v2, clr2, wr2, busy2, done2, err2;
  logic [31:0] i2, j2, k2;

  logic        start3 = 1'b0;
  logic        v3, clr3, wr3, busy3, done3, err3;
  logic [31:0] i3, j3, k3;

  logic        starte = 1'b0;
  logic        ve, clre, wre, busye, donee, erre;
  logic [31:0] ie, je, ke;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mmul2_sequencer #(.RA(2), .CA(2), .RB(2), .CB(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
    .step_ready(step_ready), .idx_valid(v2), .i(i2), .j(j2), .k(k2),
    .acc_clr(clr2), .acc_wr(wr2), .busy(busy2), .done(done2),
    .cfg_err(err2)
  );

  mmul2_sequencer #(.RA(2), .CA(3), .RB(3), .CB(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort),
    .step_ready(step_ready), .idx_valid(v3), .i(i3), .j(j3), .k(k3),
    .acc_clr(clr3), .acc_wr(wr3), .busy(busy3), .done(done3),
    .cfg_err(err3)
  );

  mmul2_sequencer #(.RA(1), .CA(2), .RB(3), .CB(1)) ue (
    .clk(clk), .rst_n(rst_n), .start(starte), .abort(abort),
    .step_ready(step_ready), .idx_valid(ve), .i(ie), .j(je), .k(ke),
    .acc_clr(clre), .acc_wr(wre), .busy(busye), .done(donee),
    .cfg_err(erre)
  );

  // full 2x2x2 sweep; stall inserts ready-low every other cycle
  // and holds start high through the run (must be ignored)
  task automatic sweep2(input bit stall);
    int ei, ej, ek, beats, cyc;
    ei = 0; ej = 0; ek = 0; beats = 0; cyc = 0;
    @(negedge clk);
    start2 = 1'b1;
    step_ready = 1'b0;
    @(negedge clk);
    if (!stall) start2 = 1'b0;
    while (beats < 8 && cyc < 40) begin
      step_ready = stall ? cyc[0] : 1'b1;
      n_checks++;
      if (v2 !== 1'b1 || busy2 !== 1'b1 || done2 !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_valid cyc=%0d: v=%b busy=%b done=%b want 1 1 0",
                 cyc, v2, busy2, done2);
      end
      n_checks++;
      if (i2 !== 32'(ei) || j2 !== 32'(ej) || k2 !== 32'(ek)) begin
        n_fail++;
        $display("FAIL sweep_idx beat=%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 beats, i2, j2, k2, ei, ej, ek);
      end
      n_checks++;
      if (clr2 !== (ek == 0) || wr2 !== (ek == 1)) begin
        n_fail++;
        $display("FAIL sweep_acc beat=%0d: clr=%b wr=%b want %b %b",
                 beats, clr2, wr2, ek == 0, ek == 1);
      end
      if (step_ready) begin
        beats++;
        if (beats == 8) start2 = 1'b0;
        ek++;
        if (ek == 2) begin ek = 0; ej++; end
        if (ej == 2) begin ej = 0; ei++; end
      end
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (beats != 8) begin
      n_fail++;
      $display("FAIL sweep_timeout: beats=%0d want 8", beats);
    end
    step_ready = 1'b0;
    n_checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || v2 !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_done: done=%b busy=%b v=%b want 1 0 0",
               done2, busy2, v2);
    end
    n_checks++;
    if (i2 !== 32'd1 || j2 !== 32'd1 || k2 !== 32'd1) begin
      n_fail++;
      $display("FAIL sweep_final_idx: got (%0d,%0d,%0d) want (1,1,1)",
               i2, j2, k2);
    end
    @(negedge clk);
    n_checks++;
    if (done2 !== 1'b0 || v2 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_after_done: done=%b v=%b busy=%b want 0 0 0",
               done2, v2, busy2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (v2 !== 0 || busy2 !== 0 || done2 !== 0 || clr2 !== 0 ||
        wr2 !== 0 || i2 !== 0 || j2 !== 0 || k2 !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b busy=%b done=%b clr=%b wr=%b i=%0d j=%0d k=%0d want all 0",
               v2, busy2, done2, clr2, wr2, i2, j2, k2);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_sweep();
    sweep2(1'b0);
  endtask

  task automatic test_stall();
    sweep2(1'b1);
  endtask

  task automatic test_accum();
    int ek, ei, beats, nclr, nwr, cyc;
    ek = 0; ei = 0; beats = 0; nclr = 0; nwr = 0; cyc = 0;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    step_ready = 1'b1;
    while (v3 === 1'b1 && cyc < 20) begin
      n_checks++;
      if (i3 !== 32'(ei) || j3 !== 32'd0 || k3 !== 32'(ek) ||
          clr3 !== (ek == 0) || wr3 !== (ek == 2)) begin
        n_fail++;
        $display("FAIL accum_beat %0d: (%0d,%0d,%0d) clr=%b wr=%b want (%0d,0,%0d) %b %b",
                 beats, i3, j3, k3, clr3, wr3, ei, ek, ek == 0, ek == 2);
      end
      if (clr3) nclr++;
      if (wr3) nwr++;
      beats++;
      ek++;
      if (ek == 3) begin ek = 0; ei++; end
      cyc++;
      @(negedge clk);
    end
    step_ready = 1'b0;
    n_checks++;
    if (beats != 6 || nclr != 2 || nwr != 2) begin
      n_fail++;
      $display("FAIL accum_counts: beats=%0d clr=%0d wr=%0d want 6 2 2",
               beats, nclr, nwr);
    end
    n_checks++;
    if (done3 !== 1'b1) begin
      n_fail++;
      $display("FAIL accum_done: done=%b want 1", done3);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    step_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (v2 !== 1'b1 || i2 !== 0 || j2 !== 1 || k2 !== 1) begin
      n_fail++;
      $display("FAIL abort_pre: v=%b (%0d,%0d,%0d) want 1 (0,1,1)",
               v2, i2, j2, k2);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    step_ready = 1'b0;
    n_checks++;
    if (busy2 !== 1'b0 || v2 !== 1'b0 || done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b v=%b done=%b want 0 0 0",
               busy2, v2, done2);
    end
    n_checks++;
    if (k2 !== 32'd1) begin
      n_fail++;
      $display("FAIL abort_beat_counted: k=%0d want 1", k2);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (done2 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: done=%b busy=%b want 0 0", done2, busy2);
    end
    sweep2(1'b0);
  endtask

  task automatic test_reset_mid();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    step_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (v2 !== 1'b1 || i2 !== 1 || j2 !== 0 || k2 !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_pre: v=%b (%0d,%0d,%0d) want 1 (1,0,0)",
               v2, i2, j2, k2);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (v2 !== 0 || busy2 !== 0 || done2 !== 0 || clr2 !== 0 ||
        wr2 !== 0 || i2 !== 0 || j2 !== 0 || k2 !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_async: v=%b busy=%b done=%b clr=%b wr=%b i=%0d j=%0d k=%0d want all 0",
               v2, busy2, done2, clr2, wr2, i2, j2, k2);
    end
    n_checks++;
    if (erre !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_cfg_err: cfg_err=%b want 1", erre);
    end
    step_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done2 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: done=%b busy=%b want 0 0", done2, busy2);
    end
    sweep2(1'b0);
  endtask

  task automatic test_cfg_err();
    bit seen;
    seen = 1'b0;
    n_checks++;
    if (erre !== 1'b1 || err2 !== 1'b0 || err3 !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_flags: bad=%b ok2=%b ok3=%b want 1 0 0",
               erre, err2, err3);
    end
    starte = 1'b1;
    step_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ve || busye || donee) seen = 1'b1;
    end
    starte = 1'b0;
    step_ready = 1'b0;
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL cfg_err_start: activity=%b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_stall();
    test_accum();
    test_abort();
    test_reset_mid();
    test_cfg_err();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
